// File: rtl/factorial_pkg.sv
// Shared definitions for the factorial engine and its BCD readout converter.
package factorial_pkg;

  localparam int unsigned N_SIZE = 3;

  // Result width of the factorial engine for an n-bit operand.
  function automatic int unsigned fact_width(input int unsigned n);
    return (32'd1 << (2 + n)) + 32'd1;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adjust
  import factorial_pkg::*;
(
  input  bcd_digit_t digit_in,
  output bcd_digit_t digit_out
);

  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) digit_out = digit_in + 4'd3;
  end

endmodule

// File: rtl/factorial_bcd_converter.sv
// Sequential binary-to-BCD converter, one double-dabble iteration per clock,
// with valid/ready handshakes on both sides.
module factorial_bcd_converter #(
  parameter int unsigned N_SIZE = factorial_pkg::N_SIZE,
  parameter int unsigned BIN_W  = factorial_pkg::fact_width(N_SIZE),
  parameter int unsigned DIGITS = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [4*DIGITS-1:0]           bcd_out,
  output logic [$clog2(DIGITS+1)-1:0]   digit_count,
  output logic                          busy
);
  import factorial_pkg::*;

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned DC_W  = $clog2(DIGITS + 1);

  if (1000 * DIGITS < 302 * BIN_W) begin : g_digits_check
    $error("DIGITS too small to hold a BIN_W-bit value");
  end

  bcd_state_e         state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_out_d;
  logic [DC_W-1:0]    digit_count_d;

  logic [BCD_W-1:0]       adj;
  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       shift_bcd;
  logic [BIN_W-1:0]       shift_bin;
  logic [DC_W-1:0]        lead;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_in  (work_q[4*g +: 4]),
      .digit_out (adj[4*g +: 4])
    );
  end

  // The BCD and binary registers shift as one concatenated word.
  assign shifted   = {adj, bin_q} << 1;
  assign shift_bcd = shifted[BCD_W+BIN_W-1:BIN_W];
  assign shift_bin = shifted[BIN_W-1:0];

  always_comb begin
    lead = DC_W'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (shift_bcd[4*i +: 4] != 4'd0) lead = DC_W'(i + 1);
    end
  end

  always_comb begin
    state_d       = state_q;
    bin_d         = bin_q;
    work_d        = work_q;
    cnt_d         = cnt_q;
    bcd_out_d     = bcd_out;
    digit_count_d = digit_count;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = bin_in;
          work_d  = '0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bin_d  = shift_bin;
        work_d = shift_bcd;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_out_d     = shift_bcd;
          digit_count_d = lead;
          state_d       = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      bcd_out     <= '0;
      digit_count <= '0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      bcd_out     <= bcd_out_d;
      digit_count <= digit_count_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT);

endmodule

// File: doc/factorial_bcd_converter.md
# factorial_bcd_converter

Sequential binary-to-BCD converter placed directly downstream of the factorial engine. It accepts one unsigned factorial result per transaction over a valid/ready handshake and converts it with the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It returns packed decimal digits plus a significant-digit count for the display/readout stage.

## Interface
- `N_SIZE`, default 3: operand width of the upstream factorial engine.
- `BIN_W`, default 2**(2+N_SIZE)+1 (33): binary input width. Equals the factorial result width.
- `DIGITS`, default 10: number of BCD output digits. Legal only if 1000*DIGITS >= 302*BIN_W; otherwise `$error` at elaboration.
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: `bin_in` is valid.
- `in_ready`, out, 1: converter can accept a value.
- `bin_in`, in, BIN_W: unsigned value to convert.
- `out_valid`, out, 1: the result is valid.
- `out_ready`, in, 1: consumer takes the result.
- `bcd_out`, out, 4*DIGITS: packed BCD. Digit 0 (units) is at [3:0].
- `digit_count`, out, $clog2(DIGITS+1): number of significant digits, range 1..DIGITS.
- `busy`, out, 1: high in the SHIFT state.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE. The reset state is IDLE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`:
    - load `bin_in` into the binary shift register;
    - clear the BCD working register;
    - set bit counter = BIN_W;
    - go to SHIFT.
- **SHIFT:**
  - Each cycle, every working digit >= 5 gets +3 (4-bit wrap, never exceeds 12).
  - Then {BCD working, binary} shifts left by 1 as one concatenated register.
  - The counter decrements.
  - When the counter reaches 1 (last iteration this edge):
    - load `bcd_out` from the post-iteration value;
    - load `digit_count` (see below);
    - go to DONE.
- **DONE:**
  - `out_valid`=1.
  - On `out_ready`=1, go to IDLE.
  - `in_ready`=0; `in_valid` is ignored.
- `digit_count` = index of the most significant non-zero digit + 1. It is 1 when the value is 0.
- `bcd_out` and `digit_count` are separate output registers. They change only on entry to DONE; intermediate shift values are never visible. They hold their value after the handshake until the next DONE entry.
- An input value is accepted only in IDLE. No handshake is dropped or duplicated.

## Timing
- Reset values:
  - state = IDLE;
  - `in_ready`=1;
  - `out_valid`=0, `busy`=0;
  - `bcd_out`=0, `digit_count`=0;
  - all working registers = 0.
- Latency: if acceptance is at edge k, `out_valid` rises after edge k+BIN_W (33 edges for the default).
- Throughput: with `out_ready` tied high, one conversion every BIN_W+2 cycles. These are the accept cycle, BIN_W shift cycles and one DONE cycle.
- DONE with `out_ready`=1 at edge m: `out_valid` falls and `in_ready` rises after edge m. A new value can be accepted at edge m+1.
- Backpressure: `out_valid`, `bcd_out` and `digit_count` stay stable for any number of cycles while `out_ready`=0.
- Reset asserted in any state (including mid-SHIFT):
  - outputs go to their reset values immediately;
  - the in-flight conversion is discarded;
  - no `out_valid` pulse follows.
- `in_ready` is a registered-state decode with no combinational path from `in_valid`. `out_valid` likewise has no combinational path from `out_ready`.

## Structure
- Shared package `factorial_pkg` holds:
  - `N_SIZE`;
  - function `fact_width(n)` = 2**(2+n)+1;
  - enum `bcd_state_e` {IDLE, SHIFT, DONE};
  - typedef `bcd_digit_t` = logic [3:0].
- The natural sub-module is `bcd_digit_adjust`: combinational add-3 if >= 5 on one `bcd_digit_t`. It is instantiated DIGITS times in a generate loop.
- The FSM, counter ($clog2(BIN_W+1) bits), shift registers and leading-zero count all live in the top module.

## Test plan
- `bin_in`=0 -> `out_valid` 33 cycles after accept; `bcd_out`=0; `digit_count`=1.
- `bin_in`=720 (6!) -> `bcd_out` digits 0000000720; `digit_count`=3.
- `bin_in`=5040 (7!), then back-to-back `bin_in`=1 with `out_ready` tied high -> 5040 with `digit_count`=4, then 1 with `digit_count`=1.
  - Second accept occurs exactly BIN_W+2 cycles after the first.
- `bin_in`=8589934591 (2**33-1) -> digits 8589934591; `digit_count`=10. This exercises every add-3 cell.
- Backpressure: hold `out_ready`=0 for 20 cycles after `out_valid` while driving `in_valid`=1 with `bin_in`=24.
  - Required: `bcd_out` stays stable, `in_ready`=0 and 24 is not captured.
  - Release `out_ready`: 24 is accepted the next cycle and yields 24 with `digit_count`=2.
- Assert `reset` low at shift cycle 10 of a 40320 conversion.
  - Required: `out_valid`, `busy`, `bcd_out` and `digit_count` go to 0 immediately and `in_ready`=1.
  - No result appears.
  - After release, converting 120 yields 120 with `digit_count`=3.
